// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: shared ALU op codes, FSM state encodings and requester IDs
//   for the ALU sharing arbiter and its round-robin sub-block.
package alu_share_arbiter_pkg;
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_NOR  = 3'b010;
   localparam logic [2:0] OP_ADD  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_LUI  = 3'b101;
   localparam logic [2:0] OP_JAL  = 3'b110;
   localparam logic [2:0] OP_IDLE = 3'b111;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;
   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/alu_share_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant.
//   clk/reset : clock, synchronous active-high reset (pointer returns to requester 0)
//   req       : request vector, bit n = requester n
//   advance   : strobe that moves the pointer away from the served requester
//   served    : ID of the requester just served
//   gnt       : one-hot (or zero) combinational grant
module rr_arbiter2
   import alu_share_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       served,
   output logic [1:0] gnt
);
   logic ptr;
   always_ff @(posedge clk) begin
      if (reset) ptr <= REQ0;
      else if (advance) ptr <= ~served;
   end
   // A lone requester wins outright; the pointer only breaks ties.
   assign gnt = (&req) ? (ptr ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters.
//   req0_*/req1_* : valid/ready operation inputs (op, a, b)
//   resp0_*/resp1_*: valid/ready result handshakes; resp_data/resp_zero are shared
//   alu_op/alu_a/alu_b : registered drive to the ALU; alu_result/alu_zero come back
//   busy          : high whenever a transaction is in flight
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int                  DATA_WIDTH = 32,
   parameter int                  OP_WIDTH   = 3,
   parameter logic [OP_WIDTH-1:0] IDLE_OP    = OP_IDLE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [OP_WIDTH-1:0]   req0_op,
   input  logic [DATA_WIDTH-1:0] req0_a,
   input  logic [DATA_WIDTH-1:0] req0_b,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [OP_WIDTH-1:0]   req1_op,
   input  logic [DATA_WIDTH-1:0] req1_a,
   input  logic [DATA_WIDTH-1:0] req1_b,
   output logic                  resp0_valid,
   input  logic                  resp0_ready,
   output logic                  resp1_valid,
   input  logic                  resp1_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_zero,
   output logic [OP_WIDTH-1:0]   alu_op,
   output logic [DATA_WIDTH-1:0] alu_a,
   output logic [DATA_WIDTH-1:0] alu_b,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_zero,
   output logic                  busy
);
   state_t              state, state_nx;
   logic                gid;
   logic [OP_WIDTH-1:0] op_q;
   logic [1:0]          gnt;
   logic                accept, resp_fire;
   // Requests are only visible to the arbiter in IDLE, so ready can never leak elsewhere.
   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     ({req1_valid, req0_valid} & {2{state == S_IDLE && !reset}}),
      .advance (resp_fire),
      .served  (gid),
      .gnt     (gnt)
   );
   assign accept      = |gnt;
   assign req0_ready  = gnt[0];
   assign req1_ready  = gnt[1];
   assign resp0_valid = state == S_RESP && gid == REQ0;
   assign resp1_valid = state == S_RESP && gid == REQ1;
   assign resp_fire   = state == S_RESP && (gid ? resp1_ready : resp0_ready);
   assign busy        = state != S_IDLE;
   assign alu_op      = state == S_EXEC ? op_q : IDLE_OP;
   always_comb begin
      state_nx = state;
      state_nx = accept            ? S_EXEC :
                 state == S_EXEC   ? S_RESP :
                 resp_fire         ? S_IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         gid       <= REQ0;
         op_q      <= IDLE_OP;
         alu_a     <= '0;
         alu_b     <= '0;
         resp_data <= '0;
         resp_zero <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            gid   <= gnt[1];
            op_q  <= gnt[1] ? req1_op : req0_op;
            alu_a <= gnt[1] ? req1_a : req0_a;
            alu_b <= gnt[1] ? req1_b : req0_b;
         end
         if (state == S_EXEC) begin
            resp_data <= alu_result;
            resp_zero <= alu_zero;
         end
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench for alu_share_arbiter with a behavioural ALU.
module tb_alu_share_arbiter;
   logic        clk = 0, reset = 1;
   logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
   logic [2:0]  req0_op = 0, req1_op = 0, alu_op;
   logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic        resp0_valid, resp1_valid, resp0_ready = 1, resp1_ready = 1;
   logic [31:0] resp_data, alu_a, alu_b, alu_result;
   logic        resp_zero, alu_zero, busy;
   int          checks = 0, fails = 0, cyc = 0;
   typedef struct {logic id; logic [31:0] res; logic zero; int cyc;} exp_t;
   exp_t sb[$];

   alu_share_arbiter dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_data(resp_data), .resp_zero(resp_zero), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [32:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = ~(a | b);
         3'b011:  r = a + b;
         3'b100:  r = a - b;
         3'b101:  r = {b[15:0], 16'h0};
         3'b110:  r = a;
         default: r = 32'h0;
      endcase
      return {r == 32'h0, r};
   endfunction
   assign {alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Monitor: push on request handshake, pop and compare on response handshake.
   initial begin
      logic        prev_v = 0, v;
      logic [31:0] hold = 0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (reset) prev_v = 0;
         else begin
            check("one_ready", {31'h0, req0_ready & req1_ready}, 0);
            if (req0_valid && req0_ready) sb.push_back('{1'b0, alu_f(req0_op, req0_a, req0_b) & 33'h0_ffff_ffff, alu_f(req0_op, req0_a, req0_b) >> 32, cyc});
            if (req1_valid && req1_ready) sb.push_back('{1'b1, alu_f(req1_op, req1_a, req1_b) & 33'h0_ffff_ffff, alu_f(req1_op, req1_a, req1_b) >> 32, cyc});
            v = resp0_valid | resp1_valid;
            if (v && !prev_v) begin
               if (sb.size() == 0) check("spurious_resp", v, 0);
               else begin
                  check("resp_id", resp1_valid, sb[0].id);
                  check("latency", cyc, sb[0].cyc + 2);
                  hold = resp_data;
               end
            end else if (v) check("resp_hold", resp_data, hold);
            if (v && sb.size() > 0 && (resp0_valid ? resp0_ready : resp1_ready)) begin
               e = sb.pop_front();
               check("resp_data", resp_data, e.res);
               check("resp_zero", resp_zero, e.zero);
            end
            prev_v = v;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int which);
      return which == 0 ? resp0_valid : which == 1 ? resp1_valid : which == 2 ? req0_ready : req1_ready;
   endfunction

   task automatic wait_for(input string tag, input int which);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sig(which) && n < 20);
      if (!sig(which)) check(tag, 0, 1);
   endtask

   task automatic apply_reset();
      reset = 1; req0_valid = 0; req1_valid = 0;
      repeat (2) tick();
      reset = 0;
   endtask

   initial begin
      int t, last;
      logic [2:0]  ops[4] = '{3'b011, 3'b100, 3'b000, 3'b010};
      logic [31:0] as[4]  = '{32'd10, 32'd3, 32'hff0f, 32'h0};
      logic [31:0] bs[4]  = '{32'd20, 32'd5, 32'h0ff0, 32'h0};
      // Reset then idle
      apply_reset();
      @(negedge clk);
      check("rst_ready", {req0_ready, req1_ready}, 0);
      check("rst_valid", {resp0_valid, resp1_valid}, 0);
      check("rst_busy", busy, 0);
      check("rst_alu_op", alu_op, 3'b111);
      check("rst_data", {resp_zero, resp_data}, 0);
      check("rst_alu_ab", {alu_a, alu_b}, 0);
      // Single add
      tick();
      req0_valid = 1; req0_op = 3'b011; req0_a = 5; req0_b = 7;
      wait_for("add_ready", 2);
      t = cyc;
      tick();
      req0_valid = 0;
      @(negedge clk);
      check("exec_alu_op", alu_op, 3'b011);
      check("exec_alu_ab", {alu_a, alu_b}, {32'd5, 32'd7});
      check("exec_busy", busy, 1);
      check("exec_no_valid", resp0_valid, 0);
      wait_for("add_resp", 0);
      check("add_lat", cyc, t + 2);
      check("add_data", resp_data, 12);
      check("add_zero", resp_zero, 0);
      check("add_resp1", resp1_valid, 0);
      tick();
      // Contention from reset
      apply_reset();
      req0_valid = 1; req0_op = 3'b100; req0_a = 9; req0_b = 9;
      req1_valid = 1; req1_op = 3'b001; req1_a = 32'hf0; req1_b = 32'h0f;
      wait_for("cont_g0", 2);
      check("cont_g0_r1", req1_ready, 0);
      tick();
      wait_for("cont_resp0", 0);
      check("sub_data", resp_data, 0);
      check("sub_zero", resp_zero, 1);
      tick();
      wait_for("cont_g1", 3);
      check("cont_g1_r0", req0_ready, 0);
      tick();
      wait_for("cont_resp1", 1);
      check("or_data", resp_data, 32'hff);
      tick();
      wait_for("cont_g2", 2);
      check("cont_g2_r1", req1_ready, 0);
      tick();
      req0_valid = 0; req1_valid = 0;
      wait_for("cont_resp2", 0);
      tick();
      // Response stall on requester 1 while requester 0 waits
      resp1_ready = 0;
      req1_valid = 1; req1_op = 3'b011; req1_a = 1; req1_b = 2;
      wait_for("stall_g1", 3);
      tick();
      req1_valid = 0;
      req0_valid = 1; req0_op = 3'b000; req0_a = 32'hffff; req0_b = 32'h0f0f;
      wait_for("stall_resp", 1);
      check("stall_data0", resp_data, 3);
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
         check("stall_valid", resp1_valid, 1);
         check("stall_data", resp_data, 3);
         check("stall_r0", req0_ready, 0);
      end
      tick();
      resp1_ready = 1;
      @(negedge clk);
      check("stall_last_r0", req0_ready, 0);
      tick();
      @(negedge clk);
      check("stall_done", resp1_valid, 0);
      check("stall_next_g0", req0_ready, 1);
      tick();
      req0_valid = 0;
      wait_for("stall_resp0", 0);
      check("and_data", resp_data, 32'h0f0f);
      tick();
      // Reset mid-operation (pointer currently favours requester 1)
      req0_valid = 1; req0_op = 3'b010; req0_a = 0; req0_b = 0;
      wait_for("mid_g0", 2);
      tick();
      req0_valid = 0; reset = 1;
      tick();
      reset = 0;
      sb.delete();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("mid_no_resp", {resp0_valid, resp1_valid}, 0);
         check("mid_busy", busy, 0);
      end
      tick();
      req0_valid = 1; req0_op = 3'b011; req0_a = 2; req0_b = 2;
      req1_valid = 1; req1_op = 3'b100; req1_a = 0; req1_b = 0;
      @(negedge clk);
      check("mid_ptr_g0", {req1_ready, req0_ready}, 2'b01);
      tick();
      req0_valid = 0; req1_valid = 0;
      wait_for("mid_resp0", 0);
      check("mid_data", resp_data, 4);
      tick();
      // Back-to-back on requester 1
      req1_valid = 1; req1_op = ops[0]; req1_a = as[0]; req1_b = bs[0];
      last = 0;
      for (int i = 0; i < 4; i++) begin
         wait_for("b2b_ready", 3);
         if (i > 0) check("b2b_gap", cyc - last, 3);
         last = cyc;
         tick();
         if (i < 3) begin
            req1_op = ops[i+1]; req1_a = as[i+1]; req1_b = bs[i+1];
         end else req1_valid = 0;
      end
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      check("drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
